// File: rtl/attractor_detect.sv
// ---------------------------------------------------------------------------
// attractor_detect
//
// Purpose:
//   Watches the stream of network states x[t] that a gene-network simulator
//   produces from one initial state. It reports the first state that repeats
//   one of the last MAX_PERIOD states. The report gives the cycle length, the
//   state that closed the cycle and the number of samples consumed. If no
//   repeat appears within MAX_STEPS samples, the run ends in a timeout.
//
// Ports:
//   clk          in   rising-edge clock for all state
//   rst          in   asynchronous, active-low reset
//   start        in   one-cycle pulse that begins a new run from init
//   init         in   initial state x[0], captured when start=1
//   x_valid      in   x carries the next state x[t+1]
//   x            in   next network state
//   busy         out  a run is in progress
//   done         out  run finished (found or timeout), sticky
//   found        out  cycle detected, sticky until start/reset
//   timeout      out  MAX_STEPS reached without detection, sticky
//   period       out  detected cycle length, 1..MAX_PERIOD
//   cycle_state  out  state that closed the cycle
//   steps        out  samples accepted when the run ended
// ---------------------------------------------------------------------------
module attractor_detect #(
    parameter int WIDTH        = 8,
    parameter int MAX_PERIOD   = 4,
    parameter int MAX_STEPS    = 16,
    parameter int REPORT_FIXED = 1,
    localparam int PW          = $clog2(MAX_PERIOD + 1),
    localparam int SW          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] init,
    input  logic             x_valid,
    input  logic [WIDTH-1:0] x,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             timeout,
    output logic [PW-1:0]    period,
    output logic [WIDTH-1:0] cycle_state,
    output logic [SW-1:0]    steps
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // hist[0] is the newest remembered state, hist[MAX_PERIOD-1] the oldest.
    logic [WIDTH-1:0] hist [MAX_PERIOD];
    logic [PW-1:0]    fill;
    logic [SW-1:0]    count;

    logic             hit;
    logic [PW-1:0]    match_k;
    logic             newest_repeat;
    logic [SW-1:0]    count_inc;
    logic             last_step;
    logic             accept;

    assign busy = (state_q == SEARCH);

    // A sample is only consumed while searching; a start in the same cycle
    // takes priority and the sample is thrown away.
    assign accept = (state_q == SEARCH) && x_valid && !start;

    assign count_inc = count + 1'b1;
    assign last_step = (count_inc == SW'(MAX_STEPS));

    // Scan the valid history from newest to oldest so that the first hit is
    // the shortest cycle. When fixed points are not reportable, distance 1 is
    // skipped entirely.
    always_comb begin
        hit     = 1'b0;
        match_k = '0;
        for (int k = 1; k <= MAX_PERIOD; k++) begin
            if (!hit && (k <= int'(fill)) && (x == hist[k-1]) &&
                !((k == 1) && (REPORT_FIXED == 0))) begin
                hit     = 1'b1;
                match_k = PW'(k);
            end
        end
        newest_repeat = (fill != '0) && (x == hist[0]);
    end

    // Run-control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: start always (re)enters SEARCH; SEARCH ends on a
    // detection or on the final allowed sample.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = SEARCH;
            end
            SEARCH: begin
                if (start) begin
                    state_d = SEARCH;
                end else if (x_valid && (hit || last_step)) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (start) state_d = SEARCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // History, counters and result registers. Results are written on the
    // same edge that accepts the closing sample and then hold until the next
    // start or reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_PERIOD; i++) begin
                hist[i] <= '0;
            end
            fill        <= '0;
            count       <= '0;
            done        <= 1'b0;
            found       <= 1'b0;
            timeout     <= 1'b0;
            period      <= '0;
            cycle_state <= '0;
            steps       <= '0;
        end else if (start) begin
            hist[0]     <= init;
            fill        <= PW'(1);
            count       <= '0;
            done        <= 1'b0;
            found       <= 1'b0;
            timeout     <= 1'b0;
            period      <= '0;
            cycle_state <= '0;
            steps       <= '0;
        end else if (accept) begin
            count <= count_inc;
            if (hit) begin
                found       <= 1'b1;
                done        <= 1'b1;
                period      <= match_k;
                cycle_state <= x;
                steps       <= count_inc;
            end else if (last_step) begin
                timeout <= 1'b1;
                done    <= 1'b1;
                steps   <= SW'(MAX_STEPS);
            end else if (!((REPORT_FIXED == 0) && newest_repeat)) begin
                // An immediate repeat of the newest state is a fixed point.
                // When fixed points are not reported it is kept out of the
                // history, otherwise it would later masquerade as a
                // longer cycle against its own earlier copy.
                for (int i = MAX_PERIOD - 1; i > 0; i--) begin
                    hist[i] <= hist[i-1];
                end
                hist[0] <= x;
                if (fill != PW'(MAX_PERIOD)) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

endmodule
